// File: rtl/upcounter_seq_ctrl_pkg.sv
// Shared widths and FSM state encoding for the up-counter sequencer.
package upcounter_seq_ctrl_pkg;

  localparam int CNT_W_DEF = 3;
  localparam int REP_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/upcounter_seq_ctrl.sv
// Sequencer that loads the counter once per pass, watches q_out for the terminal
// value and repeats the window rep+1 times before pulsing done.
module upcounter_seq_ctrl
  import upcounter_seq_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int REP_W = REP_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] start_val,
  input  logic [CNT_W-1:0] end_val,
  input  logic [REP_W-1:0] repeat_cnt,
  input  logic             abort,
  input  logic [CNT_W-1:0] q_out,
  output logic             load_en,
  output logic [CNT_W-1:0] data_in,
  output logic             busy,
  output logic             tc_hit,
  output logic [REP_W-1:0] pass_idx,
  output logic             done,
  output logic             aborted
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] start_val_reg;
  logic [CNT_W-1:0] end_val_reg;
  logic [REP_W-1:0] rep_reg;
  logic [REP_W-1:0] pass_idx_reg;
  logic             aborted_reg;
  logic             tc_match;
  logic             last_pass;
  logic             in_window;

  assign tc_match  = (state_reg == RUN) && (q_out == end_val_reg);
  assign last_pass = (pass_idx_reg == rep_reg);
  assign in_window = (state_reg == LOAD) || (state_reg == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      start_val_reg <= '0;
      end_val_reg   <= '0;
      rep_reg       <= '0;
      pass_idx_reg  <= '0;
      aborted_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      aborted_reg <= in_window && abort;
      if (state_reg == IDLE && start) begin
        start_val_reg <= start_val;
        end_val_reg   <= end_val;
        rep_reg       <= repeat_cnt;
        pass_idx_reg  <= '0;
      end
      // abort wins over the pass advance even when the terminal value is hit
      if (tc_match && !abort && !last_pass) begin
        pass_idx_reg <= pass_idx_reg + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = LOAD;
      LOAD: state_next = abort ? IDLE : RUN;
      RUN: begin
        if (abort)         state_next = IDLE;
        else if (tc_match) state_next = last_pass ? DONE : LOAD;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load_en  = (state_reg == LOAD);
    data_in  = (state_reg == LOAD) ? start_val_reg : '0;
    busy     = in_window;
    tc_hit   = tc_match;
    done     = (state_reg == DONE);
    aborted  = aborted_reg;
    pass_idx = pass_idx_reg;
  end

endmodule
